// File: rtl/mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mul_sequencer
//  Description : Multi-cycle RV32M multiplier (MUL/MULH/MULHSU/MULHU), radix-2
//                shift-add over 32 cycles on sign-corrected magnitudes.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    input  logic            i_kill,
    output logic            o_busy,
    output logic            o_stall,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [5:0] c_LAST_ITER = 6'd31;

    state_t              r_state_q,  w_state_d;
    logic [5:0]          r_cnt_q,    w_cnt_d;
    logic [2*XLEN-1:0]   r_acc_q,    w_acc_d;
    logic [XLEN-1:0]     r_mcand_q,  w_mcand_d;
    logic                r_neg_q,    w_neg_d;
    logic                r_hi_q,     w_hi_d;
    logic [XLEN-1:0]     r_result_q, w_result_d;

    logic                w_accept;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic [XLEN:0]       w_step_sum;
    logic [2*XLEN-1:0]   w_acc_step;
    logic [2*XLEN-1:0]   w_product;

    // a is signed for funct3[1:0] != 11, b is signed only when funct3[1] == 0
    assign w_a_neg  = (i_funct3[1:0] != 2'b11) & i_op_a[XLEN-1];
    assign w_b_neg  = ~i_funct3[1] & i_op_b[XLEN-1];
    assign w_mag_a  = w_a_neg ? (~i_op_a + 1'b1) : i_op_a;
    assign w_mag_b  = w_b_neg ? (~i_op_b + 1'b1) : i_op_b;
    assign w_accept = (r_state_q == S_IDLE) & i_start & ~i_funct3[2] & ~i_kill;

    // Multiplier sits in the low half and shifts out LSB first while the
    // partial sum grows into the high half.
    assign w_step_sum = {1'b0, r_acc_q[2*XLEN-1:XLEN]}
                      + {1'b0, (r_acc_q[0] ? r_mcand_q : {XLEN{1'b0}})};
    assign w_acc_step = {w_step_sum, r_acc_q[XLEN-1:1]};
    assign w_product  = r_neg_q ? (~w_acc_step + 1'b1) : w_acc_step;

    always_comb begin
        w_state_d  = r_state_q;
        w_cnt_d    = r_cnt_q;
        w_acc_d    = r_acc_q;
        w_mcand_d  = r_mcand_q;
        w_neg_d    = r_neg_q;
        w_hi_d     = r_hi_q;
        w_result_d = r_result_q;
        o_busy     = 1'b0;
        o_stall    = 1'b0;
        o_valid    = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_d = S_CALC;
                    w_cnt_d   = 6'd0;
                    w_acc_d   = {{XLEN{1'b0}}, w_mag_b};
                    w_mcand_d = w_mag_a;
                    w_neg_d   = (w_a_neg ^ w_b_neg) & (|w_mag_a) & (|w_mag_b);
                    w_hi_d    = (i_funct3[1:0] != 2'b00);
                    o_stall   = 1'b1;
                end
            end
            S_CALC: begin
                o_busy  = 1'b1;
                o_stall = 1'b1;
                if (i_kill) begin
                    w_state_d = S_IDLE;
                    w_cnt_d   = 6'd0;
                end else begin
                    w_acc_d = w_acc_step;
                    w_cnt_d = r_cnt_q + 6'd1;
                    if (r_cnt_q == c_LAST_ITER) begin
                        w_state_d  = S_DONE;
                        w_cnt_d    = 6'd0;
                        w_result_d = r_hi_q ? w_product[2*XLEN-1:XLEN]
                                            : w_product[XLEN-1:0];
                    end
                end
            end
            S_DONE: begin
                o_busy    = 1'b1;
                o_valid   = ~i_kill;
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state_q  <= S_IDLE;
            r_cnt_q    <= 6'd0;
            r_acc_q    <= {2*XLEN{1'b0}};
            r_mcand_q  <= {XLEN{1'b0}};
            r_neg_q    <= 1'b0;
            r_hi_q     <= 1'b0;
            r_result_q <= {XLEN{1'b0}};
        end else begin
            r_state_q  <= w_state_d;
            r_cnt_q    <= w_cnt_d;
            r_acc_q    <= w_acc_d;
            r_mcand_q  <= w_mcand_d;
            r_neg_q    <= w_neg_d;
            r_hi_q     <= w_hi_d;
            r_result_q <= w_result_d;
        end
    end

    assign o_result = r_result_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_sequencer
//  Description : Directed self-checking bench for mul_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_sequencer;

    localparam int c_LATENCY = 33;  // accepting edge counted as edge 1

    logic        r_clk = 1'b0;
    logic        r_rst;
    logic        r_start;
    logic [2:0]  r_funct3;
    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic        r_kill;
    logic        w_busy;
    logic        w_stall;
    logic        w_valid;
    logic [31:0] w_result;

    int tests = 0;
    int fails = 0;

    mul_sequencer #(.XLEN(32)) u_dut (
        .i_clk    (r_clk),
        .i_rst    (r_rst),
        .i_start  (r_start),
        .i_funct3 (r_funct3),
        .i_op_a   (r_op_a),
        .i_op_b   (r_op_b),
        .i_kill   (r_kill),
        .o_busy   (w_busy),
        .o_stall  (w_stall),
        .o_valid  (w_valid),
        .o_result (w_result)
    );

    always #5 r_clk = ~r_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Presents a start at a negedge, checks the stall, and returns just after the accepting edge.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic hold);
        @(negedge r_clk);
        r_start  = 1'b1;
        r_funct3 = f3;
        r_op_a   = a;
        r_op_b   = b;
        #1 check("accept_stall", {31'b0, w_stall}, 32'd1);
        @(posedge r_clk);
        #1;
        if (!hold) r_start = 1'b0;
        r_op_a   = $urandom;
        r_op_b   = $urandom;
        r_funct3 = 3'($urandom_range(0, 3));
    endtask

    // Waits (bounded) for o_valid and checks latency, result and handshake.
    task automatic wait_done(input string tag, input logic [31:0] exp);
        int  n;
        bit  seen;
        n    = 1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge r_clk);
            n++;
            @(negedge r_clk);
            if (w_valid) seen = 1'b1;
        end
        check({tag, "_latency"}, seen ? 32'(n) : 32'd0, 32'(c_LATENCY));
        check({tag, "_result"}, w_result, exp);
        check({tag, "_stall_in_done"}, {31'b0, w_stall}, 32'd0);
        check({tag, "_busy_in_done"}, {31'b0, w_busy}, 32'd1);
        @(posedge r_clk);
        @(negedge r_clk);
        check({tag, "_valid_pulse"}, {31'b0, w_valid}, 32'd0);
        check({tag, "_idle_busy"}, {31'b0, w_busy}, 32'd0);
    endtask

    task automatic count_valid(input string tag, input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge r_clk);
            if (w_valid) pulses++;
        end
        check(tag, 32'(pulses), 32'd0);
    endtask

    logic [2:0]  vec_f3  [8] = '{3'b000, 3'b001, 3'b000, 3'b011, 3'b010,
                                 3'b001, 3'b000, 3'b010};
    logic [31:0] vec_a   [8] = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1234, 32'h8000_0000};
    logic [31:0] vec_b   [8] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                                 32'hFFFF_FFFF, 32'd0, 32'd5678, 32'h8000_0000};
    logic [31:0] vec_exp [8] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h0000_0000, 32'hFFFF_FFFE,
                                 32'hFFFF_FFFF, 32'h0000_0000, 32'h006A_E9BC, 32'hC000_0000};

    initial begin
        r_rst    = 1'b1;
        r_start  = 1'b0;
        r_kill   = 1'b0;
        r_funct3 = 3'b000;
        r_op_a   = 32'd0;
        r_op_b   = 32'd0;
        #1;
        check("reset_busy",   {31'b0, w_busy},  32'd0);
        check("reset_valid",  {31'b0, w_valid}, 32'd0);
        check("reset_stall",  {31'b0, w_stall}, 32'd0);
        check("reset_result", w_result, 32'd0);
        @(negedge r_clk);
        r_rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            issue(vec_f3[i], vec_a[i], vec_b[i], 1'b0);
            wait_done($sformatf("vec%0d", i), vec_exp[i]);
        end

        // funct3[2]=1 is not a multiply and must be ignored
        @(negedge r_clk);
        r_start  = 1'b1;
        r_funct3 = 3'b100;
        #1 check("div_ignored_stall", {31'b0, w_stall}, 32'd0);
        @(posedge r_clk);
        #1 r_start = 1'b0;
        check("div_ignored_busy", {31'b0, w_busy}, 32'd0);

        // asynchronous reset in CALC cycle 10 (prior result 0xC0000000)
        issue(3'b000, 32'd1234, 32'd5678, 1'b0);
        repeat (10) @(posedge r_clk);
        #2 r_rst = 1'b1;
        #1;
        check("midreset_busy",   {31'b0, w_busy},  32'd0);
        check("midreset_stall",  {31'b0, w_stall}, 32'd0);
        check("midreset_result", w_result, 32'd0);
        @(negedge r_clk);
        r_rst = 1'b0;
        count_valid("midreset_no_valid", 40);
        issue(3'b011, 32'h0001_0000, 32'h0001_0000, 1'b0);
        wait_done("after_reset", 32'h0000_0001);

        // kill in CALC cycle 5: result stays at 0x00000001
        issue(3'b000, 32'd3, 32'd4, 1'b0);
        repeat (5) @(posedge r_clk);
        @(negedge r_clk);
        r_kill = 1'b1;
        @(posedge r_clk);
        #1 r_kill = 1'b0;
        check("kill_busy", {31'b0, w_busy}, 32'd0);
        count_valid("kill_no_valid", 40);
        check("kill_result_held", w_result, 32'h0000_0001);

        // kill and start together in IDLE
        @(negedge r_clk);
        r_start  = 1'b1;
        r_kill   = 1'b1;
        r_funct3 = 3'b000;
        r_op_a   = 32'd2;
        r_op_b   = 32'd2;
        #1 check("killstart_stall", {31'b0, w_stall}, 32'd0);
        @(posedge r_clk);
        #1;
        r_start = 1'b0;
        r_kill  = 1'b0;
        check("killstart_busy", {31'b0, w_busy}, 32'd0);

        // start held high with changing operands: only the first op, then a re-accept
        issue(3'b000, 32'd3, 32'd5, 1'b1);
        r_funct3 = 3'b000;
        r_op_a   = 32'd100;
        r_op_b   = 32'd2;
        wait_done("hold_first", 32'd15);
        check("hold_restart_stall", {31'b0, w_stall}, 32'd1);
        @(posedge r_clk);
        #1 r_start = 1'b0;
        wait_done("hold_second", 32'd200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 Parameter XLEN, default 32, operand and result width; only 32 is supported.
REQ-002 i_clk  input  1  sole clock, rising-edge.
REQ-003 i_rst  input  1  reset, asynchronous, active-high.
REQ-004 i_start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 i_funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
REQ-006 i_op_a  input  32  rs1 operand.
REQ-007 i_op_b  input  32  rs2 operand.
REQ-008 i_kill  input  1  synchronous abort from the core (flush).
REQ-009 o_busy  output  1  high while in CALC or DONE.
REQ-010 o_stall  output  1  combinational; freezes the core's PC and writeback.
REQ-011 o_valid  output  1  one-cycle pulse when o_result is valid.
REQ-012 o_result  output  32  selected product half.

Function
REQ-013 FSM states SHALL be IDLE, CALC, DONE.
REQ-014 IDLE -> CALC on i_start=1, i_funct3[2]=0 and i_kill=0; otherwise stay IDLE.
REQ-015 Start with i_funct3[2]=1 SHALL be ignored: no state change, o_stall=0.
REQ-016 On accept, the block SHALL latch operands, funct3, signs and magnitudes; later input changes have no effect.
REQ-017 Signedness: a signed for MUL/MULH/MULHSU; b signed for MUL/MULH; unsigned otherwise.
REQ-018 Magnitude = two's-complement negate if operand signed and bit 31 set, else raw value.
REQ-019 CALC SHALL run exactly 32 cycles of radix-2 shift-add on a 64-bit accumulator, one multiplier bit per cycle, LSB first, via a 6-bit iteration counter.
REQ-020 After the 32nd CALC cycle -> DONE; DONE lasts one cycle -> IDLE.
REQ-021 Final 64-bit product SHALL be negated when latched signs differ and both magnitudes are non-zero.
REQ-022 o_result = product[31:0] for MUL, product[63:32] for MULH/MULHSU/MULHU.
REQ-023 o_result SHALL be registered, updated on entry to DONE, and held until the next DONE or reset.
REQ-024 o_valid=1 only in DONE; latency from the accepting edge to o_valid high = 33 cycles.
REQ-025 o_stall = (IDLE and accepted start) or CALC; o_stall=0 in DONE so the core retires that cycle.
REQ-026 i_start while busy SHALL be ignored; no queuing.
REQ-027 i_kill=1 in CALC or DONE SHALL return the FSM to IDLE next edge, suppress o_valid, and leave o_result unchanged.
REQ-028 i_kill and i_start both high in IDLE: kill wins and the start is not accepted.
REQ-029 Zero operand SHALL still take the full 33-cycle latency; no early-out.

Reset
REQ-030 On i_rst=1, immediately and regardless of clock: state=IDLE, counter=0, accumulator=0, o_result=0, o_valid=0, o_busy=0, o_stall=0.
REQ-031 Reset asserted mid-CALC SHALL abort the operation with no o_valid pulse.
REQ-032 After release, the first rising edge with i_start=1 SHALL be accepted normally.

Verification
REQ-033 MUL a=7, b=0xFFFFFFFD -> o_valid exactly 33 cycles after accept, o_result=0xFFFFFFEB, o_stall low in the o_valid cycle.
REQ-034 MULH 0x80000000 x 0x80000000 -> 0x40000000; MUL with the same operands -> 0x00000000.
REQ-035 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULH 0xFFFFFFFF x 0 -> 0.
REQ-036 i_rst pulsed at CALC cycle 10 -> o_busy=0 and o_result=0 immediately; no o_valid for 40 cycles; next start completes correctly.
REQ-037 New operands and i_start held high throughout busy -> result reflects the first operands only, then one further accept in the IDLE cycle after DONE.
REQ-038 i_kill at CALC cycle 5 -> IDLE next cycle, no o_valid, o_result keeps the prior value; kill+start together in IDLE -> no accept.
